// File: rtl/issue_queue_sched.sv
// -----------------------------------------------------------------------------
// issue_queue_sched
//   Unified collapsing issue queue for ADD/MUL micro-ops. Entry 0 is the oldest
//   and valid entries are packed from index 0. Operands are woken by the two
//   result broadcasts. Each cycle the oldest ready ADD and the oldest ready MUL
//   are selected and driven on the issue ports. Selected entries are removed at
//   the clock edge and younger entries shift down to close the gaps.
//
// Optional build macro:
//   WAKEUP_BYPASS_EN - select also treats an operand as ready when it matches a
//                      valid broadcast in the current cycle (same-cycle issue).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   flush                    synchronous clear of all entries, beats dispatch
//   valid_dispatch ...       dispatch request and micro-op fields
//   valid_Result_add/_mul,
//   tag_PRF_add/_mul         result broadcasts used for wakeup
//   freeze_back              back-end stall: no issue, no removal
//   full_IQ, count           occupancy
//   valid_add/_mul + tags    issue ports (tags are 0 while not valid)
// -----------------------------------------------------------------------------
module issue_queue_sched #(
    parameter int DEPTH = 8,
    parameter int PRF_W = 5,
    parameter int ROB_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     valid_dispatch,
    input  logic                     op_mul_in,
    input  logic [PRF_W-1:0]         tag_Ra_in,
    input  logic [PRF_W-1:0]         tag_Rb_in,
    input  logic                     rdy_Ra_in,
    input  logic                     rdy_Rb_in,
    input  logic [PRF_W-1:0]         tag_PRF_in,
    input  logic [ROB_W-1:0]         tag_ROB_in,
    input  logic                     valid_Result_add,
    input  logic                     valid_Result_mul,
    input  logic [PRF_W-1:0]         tag_PRF_add,
    input  logic [PRF_W-1:0]         tag_PRF_mul,
    input  logic                     freeze_back,
    output logic                     full_IQ,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid_add,
    output logic                     valid_mul,
    output logic [PRF_W-1:0]         tag_Ra_add,
    output logic [PRF_W-1:0]         tag_Rb_add,
    output logic [PRF_W-1:0]         tag_PRF_add_out,
    output logic [ROB_W-1:0]         tag_ROB_add_out,
    output logic [PRF_W-1:0]         tag_Ra_mul,
    output logic [PRF_W-1:0]         tag_Rb_mul,
    output logic [PRF_W-1:0]         tag_PRF_mul_out,
    output logic [ROB_W-1:0]         tag_ROB_mul_out
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic             op;   // 0 = ADD, 1 = MUL
        logic [PRF_W-1:0] ta;
        logic             ra;
        logic [PRF_W-1:0] tb;
        logic             rb;
        logic [PRF_W-1:0] tp;
        logic [ROB_W-1:0] tr;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           q_n   [DEPTH];
    logic [DEPTH-1:0] vld, vld_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic [DEPTH-1:0] hit_a, hit_b;
    logic [DEPTH-1:0] sel_rdy_a, sel_rdy_b;
    logic             hit_in_a, hit_in_b;

    logic             found_add, found_mul;
    logic [IW-1:0]    idx_add, idx_mul;
    logic [DEPTH-1:0] oh_add, oh_mul;
    logic [DEPTH-1:0] remove;
    logic             accept;
    logic [CW-1:0]    k;
    entry_t           e;

    // Broadcast tag matches for stored entries and for the incoming dispatch.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_a[i] = (valid_Result_add && q[i].ta == tag_PRF_add) ||
                       (valid_Result_mul && q[i].ta == tag_PRF_mul);
            hit_b[i] = (valid_Result_add && q[i].tb == tag_PRF_add) ||
                       (valid_Result_mul && q[i].tb == tag_PRF_mul);
        end
        hit_in_a = (valid_Result_add && tag_Ra_in == tag_PRF_add) ||
                   (valid_Result_mul && tag_Ra_in == tag_PRF_mul);
        hit_in_b = (valid_Result_add && tag_Rb_in == tag_PRF_add) ||
                   (valid_Result_mul && tag_Rb_in == tag_PRF_mul);
    end

    // Operand readiness as seen by select.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef WAKEUP_BYPASS_EN
            sel_rdy_a[i] = q[i].ra | hit_a[i];
            sel_rdy_b[i] = q[i].rb | hit_b[i];
`else
            sel_rdy_a[i] = q[i].ra;
            sel_rdy_b[i] = q[i].rb;
`endif
        end
    end

    // Oldest-first select per functional unit.
    always_comb begin
        found_add = 1'b0;
        found_mul = 1'b0;
        idx_add   = '0;
        idx_mul   = '0;
        oh_add    = '0;
        oh_mul    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found_add && vld[i] && !q[i].op && sel_rdy_a[i] && sel_rdy_b[i]) begin
                found_add = 1'b1;
                idx_add   = IW'(i);
                oh_add[i] = 1'b1;
            end
            if (!found_mul && vld[i] && q[i].op && sel_rdy_a[i] && sel_rdy_b[i]) begin
                found_mul = 1'b1;
                idx_mul   = IW'(i);
                oh_mul[i] = 1'b1;
            end
        end
    end

    assign valid_add = found_add & ~freeze_back;
    assign valid_mul = found_mul & ~freeze_back;
    assign remove    = (valid_add ? oh_add : '0) | (valid_mul ? oh_mul : '0);

    assign tag_Ra_add      = valid_add ? q[idx_add].ta : '0;
    assign tag_Rb_add      = valid_add ? q[idx_add].tb : '0;
    assign tag_PRF_add_out = valid_add ? q[idx_add].tp : '0;
    assign tag_ROB_add_out = valid_add ? q[idx_add].tr : '0;
    assign tag_Ra_mul      = valid_mul ? q[idx_mul].ta : '0;
    assign tag_Rb_mul      = valid_mul ? q[idx_mul].tb : '0;
    assign tag_PRF_mul_out = valid_mul ? q[idx_mul].tp : '0;
    assign tag_ROB_mul_out = valid_mul ? q[idx_mul].tr : '0;

    assign full_IQ = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign accept  = valid_dispatch & ~full_IQ & ~flush;

    // Collapse: surviving entries are repacked in order from slot 0 with this
    // cycle's wakeups applied; k ends as the post-issue occupancy, which is
    // where an accepted dispatch lands. Accept implies cnt < DEPTH, so k never
    // wraps before that write.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            q_n[i] = '0;
        end
        vld_n = '0;
        k     = '0;
        e     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] && !remove[i]) begin
                e    = q[i];
                e.ra = q[i].ra | hit_a[i];
                e.rb = q[i].rb | hit_b[i];
                q_n[k[IW-1:0]]   = e;
                vld_n[k[IW-1:0]] = 1'b1;
                k = k + CW'(1);
            end
        end
        if (accept) begin
            e.op = op_mul_in;
            e.ta = tag_Ra_in;
            e.ra = rdy_Ra_in | hit_in_a;
            e.tb = tag_Rb_in;
            e.rb = rdy_Rb_in | hit_in_b;
            e.tp = tag_PRF_in;
            e.tr = tag_ROB_in;
            q_n[k[IW-1:0]]   = e;
            vld_n[k[IW-1:0]] = 1'b1;
        end
        cnt_n = k + CW'(accept);
        if (flush) begin
            vld_n = '0;
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            vld <= vld_n;
            cnt <= cnt_n;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= q_n[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_sched.sv
module tb_issue_queue_sched;

    localparam int DEPTH = 8;
    localparam int PRF_W = 5;
    localparam int ROB_W = 4;
`ifdef WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, flush, valid_dispatch, op_mul_in;
    logic [PRF_W-1:0] tag_Ra_in, tag_Rb_in, tag_PRF_in;
    logic rdy_Ra_in, rdy_Rb_in;
    logic [ROB_W-1:0] tag_ROB_in;
    logic valid_Result_add, valid_Result_mul;
    logic [PRF_W-1:0] tag_PRF_add, tag_PRF_mul;
    logic freeze_back;
    logic full_IQ;
    logic [$clog2(DEPTH):0] count;
    logic valid_add, valid_mul;
    logic [PRF_W-1:0] tag_Ra_add, tag_Rb_add, tag_PRF_add_out;
    logic [ROB_W-1:0] tag_ROB_add_out;
    logic [PRF_W-1:0] tag_Ra_mul, tag_Rb_mul, tag_PRF_mul_out;
    logic [ROB_W-1:0] tag_ROB_mul_out;

    issue_queue_sched #(.DEPTH(DEPTH), .PRF_W(PRF_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_dispatch(valid_dispatch), .op_mul_in(op_mul_in),
        .tag_Ra_in(tag_Ra_in), .tag_Rb_in(tag_Rb_in),
        .rdy_Ra_in(rdy_Ra_in), .rdy_Rb_in(rdy_Rb_in),
        .tag_PRF_in(tag_PRF_in), .tag_ROB_in(tag_ROB_in),
        .valid_Result_add(valid_Result_add), .valid_Result_mul(valid_Result_mul),
        .tag_PRF_add(tag_PRF_add), .tag_PRF_mul(tag_PRF_mul),
        .freeze_back(freeze_back),
        .full_IQ(full_IQ), .count(count),
        .valid_add(valid_add), .valid_mul(valid_mul),
        .tag_Ra_add(tag_Ra_add), .tag_Rb_add(tag_Rb_add),
        .tag_PRF_add_out(tag_PRF_add_out), .tag_ROB_add_out(tag_ROB_add_out),
        .tag_Ra_mul(tag_Ra_mul), .tag_Rb_mul(tag_Rb_mul),
        .tag_PRF_mul_out(tag_PRF_mul_out), .tag_ROB_mul_out(tag_ROB_mul_out)
    );

    always #5 clk = ~clk;

    // Reference model: an age-ordered list of micro-ops; index 0 is oldest.
    typedef struct {
        bit op;
        int ta;
        bit ra;
        int tb;
        bit rb;
        int tp;
        int tr;
    } ment_t;

    ment_t mq[$];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic bit hit(int t);
        return (valid_Result_add && t == int'(tag_PRF_add)) ||
               (valid_Result_mul && t == int'(tag_PRF_mul));
    endfunction

    function automatic bit eff(int t, bit r);
        return r || (BYP && hit(t));
    endfunction

    function automatic int pick(bit m);
        if (freeze_back) return -1;
        foreach (mq[i]) begin
            if (mq[i].op == m && eff(mq[i].ta, mq[i].ra) && eff(mq[i].tb, mq[i].rb))
                return i;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model, 1 time unit after inputs change.
    task automatic eval();
        int ia, im;
        #1;
        ia = pick(1'b0);
        im = pick(1'b1);
        chk("count",     int'(count),     mq.size());
        chk("full_IQ",   int'(full_IQ),   int'(mq.size() == DEPTH));
        chk("valid_add", int'(valid_add), int'(ia >= 0));
        chk("valid_mul", int'(valid_mul), int'(im >= 0));
        chk("tag_Ra_add",      int'(tag_Ra_add),      ia >= 0 ? mq[ia].ta : 0);
        chk("tag_Rb_add",      int'(tag_Rb_add),      ia >= 0 ? mq[ia].tb : 0);
        chk("tag_PRF_add_out", int'(tag_PRF_add_out), ia >= 0 ? mq[ia].tp : 0);
        chk("tag_ROB_add_out", int'(tag_ROB_add_out), ia >= 0 ? mq[ia].tr : 0);
        chk("tag_Ra_mul",      int'(tag_Ra_mul),      im >= 0 ? mq[im].ta : 0);
        chk("tag_Rb_mul",      int'(tag_Rb_mul),      im >= 0 ? mq[im].tb : 0);
        chk("tag_PRF_mul_out", int'(tag_PRF_mul_out), im >= 0 ? mq[im].tp : 0);
        chk("tag_ROB_mul_out", int'(tag_ROB_mul_out), im >= 0 ? mq[im].tr : 0);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic adv();
        int ia, im, sz;
        ment_t n;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            sz = mq.size();
            ia = pick(1'b0);
            im = pick(1'b1);
            if (ia > im) begin
                mq.delete(ia);
                if (im >= 0) mq.delete(im);
            end else begin
                if (im >= 0) mq.delete(im);
                if (ia >= 0) mq.delete(ia);
            end
            foreach (mq[i]) begin
                if (hit(mq[i].ta)) mq[i].ra = 1'b1;
                if (hit(mq[i].tb)) mq[i].rb = 1'b1;
            end
            if (valid_dispatch && sz < DEPTH) begin
                n.op = op_mul_in;
                n.ta = int'(tag_Ra_in);
                n.ra = rdy_Ra_in || hit(int'(tag_Ra_in));
                n.tb = int'(tag_Rb_in);
                n.rb = rdy_Rb_in || hit(int'(tag_Rb_in));
                n.tp = int'(tag_PRF_in);
                n.tr = int'(tag_ROB_in);
                mq.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    task automatic idle();
        flush = 1'b0; valid_dispatch = 1'b0; op_mul_in = 1'b0;
        tag_Ra_in = '0; tag_Rb_in = '0; rdy_Ra_in = 1'b0; rdy_Rb_in = 1'b0;
        tag_PRF_in = '0; tag_ROB_in = '0;
        valid_Result_add = 1'b0; valid_Result_mul = 1'b0;
        tag_PRF_add = '0; tag_PRF_mul = '0; freeze_back = 1'b0;
    endtask

    task automatic disp(bit op, int ta, bit ra, int tb, bit rb, int tp, int tr);
        idle();
        valid_dispatch = 1'b1; op_mul_in = op;
        tag_Ra_in = PRF_W'(ta); rdy_Ra_in = ra;
        tag_Rb_in = PRF_W'(tb); rdy_Rb_in = rb;
        tag_PRF_in = PRF_W'(tp); tag_ROB_in = ROB_W'(tr);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_full", int'(full_IQ), 0);
        chk("reset_valid_add", int'(valid_add), 0);
        chk("reset_valid_mul", int'(valid_mul), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Ready ADD issues the cycle after dispatch.
        disp(0, 3, 1, 4, 1, 10, 1);
        tick();
        idle();
        eval();
        chk("t1_valid_add", int'(valid_add), 1);
        chk("t1_dst", int'(tag_PRF_add_out), 10);
        chk("t1_rob", int'(tag_ROB_add_out), 1);
        chk("t1_ra", int'(tag_Ra_add), 3);
        adv();
        eval();
        chk("t1_count_after", int'(count), 0);
        adv();

        // MUL woken by the ADD broadcast two cycles after dispatch.
        disp(1, 7, 0, 2, 1, 11, 2);
        tick();
        idle();
        tick();
        valid_Result_add = 1'b1; tag_PRF_add = 5'd7;
        eval();
        chk("t2_mul_bcast_cycle", int'(valid_mul), int'(BYP));
        adv();
        idle();
        eval();
        chk("t2_mul_next_cycle", int'(valid_mul), int'(!BYP));
        adv();
        tick();

        // Oldest ready wins; the blocked oldest entry stays put.
        disp(0, 9, 0, 9, 0, 20, 3);
        tick();
        disp(0, 1, 1, 2, 1, 21, 4);
        tick();
        disp(0, 1, 1, 2, 1, 22, 5);
        eval();
        chk("t3_first", int'(tag_PRF_add_out), 21);
        adv();
        idle();
        eval();
        chk("t3_second", int'(tag_PRF_add_out), 22);
        adv();
        eval();
        chk("t3_left", int'(count), 1);
        chk("t3_blocked", int'(valid_add), 0);
        adv();
        valid_Result_mul = 1'b1; tag_PRF_mul = 5'd9;
        tick();
        idle();
        tick();
        tick();

        // Fill, drop a dispatch at full, then dual issue frees two slots.
        for (int i = 0; i < DEPTH; i++) begin
            disp(i[0], 16 + i, 0, 2, 1, i, i);
            tick();
        end
        idle();
        eval();
        chk("t4_full", int'(full_IQ), 1);
        chk("t4_count8", int'(count), 8);
        adv();
        disp(0, 1, 1, 1, 1, 30, 9);
        tick();
        idle();
        eval();
        chk("t4_dropped", int'(count), 8);
        adv();
        valid_Result_add = 1'b1; tag_PRF_add = 5'd16;
        valid_Result_mul = 1'b1; tag_PRF_mul = 5'd17;
        eval();
        chk("t4_add_bcast", int'(valid_add), int'(BYP));
        chk("t4_mul_bcast", int'(valid_mul), int'(BYP));
        adv();
        idle();
        eval();
        chk("t4_add_next", int'(valid_add), int'(!BYP));
        chk("t4_mul_next", int'(valid_mul), int'(!BYP));
        chk("t4_count_mid", int'(count), BYP ? 6 : 8);
        adv();
        eval();
        chk("t4_count6", int'(count), 6);
        chk("t4_not_full", int'(full_IQ), 0);
        adv();
        flush = 1'b1;
        tick();
        idle();
        eval();
        chk("flush_count", int'(count), 0);
        chk("flush_valid_add", int'(valid_add), 0);
        adv();

        // Freeze holds a ready ADD for three cycles.
        disp(0, 1, 1, 2, 1, 12, 6);
        tick();
        idle();
        freeze_back = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t5_frozen_valid", int'(valid_add), 0);
            chk("t5_frozen_count", int'(count), 1);
            adv();
        end
        freeze_back = 1'b0;
        eval();
        chk("t5_release", int'(valid_add), 1);
        adv();

        // Asynchronous reset with five entries in flight.
        for (int i = 0; i < 5; i++) begin
            disp(i[0], 24 + i, 0, 2, 1, i, i);
            tick();
        end
        idle();
        eval();
        chk("t6_count5", int'(count), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_valid_add", int'(valid_add), 0);
        chk("t6_rst_valid_mul", int'(valid_mul), 0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Randomized traffic with a narrow tag space so wakeups are frequent.
        for (int c = 0; c < 3000; c++) begin
            idle();
            valid_dispatch   = ($urandom_range(0, 99) < 60);
            op_mul_in        = 1'($urandom_range(0, 1));
            tag_Ra_in        = PRF_W'($urandom_range(0, 7));
            tag_Rb_in        = PRF_W'($urandom_range(0, 7));
            rdy_Ra_in        = ($urandom_range(0, 99) < 40);
            rdy_Rb_in        = ($urandom_range(0, 99) < 40);
            tag_PRF_in       = PRF_W'($urandom_range(0, 31));
            tag_ROB_in       = ROB_W'($urandom_range(0, 15));
            valid_Result_add = ($urandom_range(0, 99) < 35);
            valid_Result_mul = ($urandom_range(0, 99) < 35);
            tag_PRF_add      = PRF_W'($urandom_range(0, 7));
            tag_PRF_mul      = PRF_W'($urandom_range(0, 7));
            freeze_back      = ($urandom_range(0, 99) < 20);
            flush            = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
